// File: rtl/tgl_hs_pkg.sv
// Shared types and constants for the two-phase handshake receiver.
package tgl_hs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FULL  = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_DATA_W      = 8;
    localparam int unsigned DEFAULT_SYNC_STAGES = 2;
    localparam int unsigned CNT_W               = 16;

endpackage

// File: rtl/tgl_sync.sv
// Multi-flop synchronizer for a single asynchronous level (SYNC_STAGES >= 2).
module tgl_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic sync_out
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
        end
    end

    assign sync_out = chain[SYNC_STAGES-1];

endmodule

// File: rtl/tgl_hs_rx.sv
// Two-phase (toggle) handshake receiver with a one-word output buffer and backpressure.
module tgl_hs_rx
    import tgl_hs_pkg::*;
#(
    parameter int unsigned DATA_W      = DEFAULT_DATA_W,
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_tgl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  xfer_cnt
);

    state_t state;
    state_t state_next;
    logic   sync_out;
    logic   req_seen;
    logic   pending;
    logic   accept;
    logic   capture;
    logic   valid_next;

    tgl_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rstn     (rstn),
        .din      (req_tgl),
        .sync_out (sync_out)
    );

    always_comb begin
        pending    = (sync_out != req_seen);
        accept     = out_valid & out_ready;
        capture    = pending & (~out_valid | out_ready);
        state_next = state;
        unique case (state)
            IDLE: begin
                if (capture) state_next = FULL;
            end
            FULL: begin
                if (capture)      state_next = FULL;
                else if (accept)  state_next = IDLE;
                else if (pending) state_next = STALL;
            end
            STALL: begin
                if (capture) state_next = FULL;
            end
            default: state_next = IDLE;
        endcase
        // out_valid is its own flop so the output carries no decode logic
        valid_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            req_seen  <= 1'b0;
            ack_tgl   <= 1'b0;
            out_data  <= '0;
            xfer_cnt  <= '0;
        end else begin
            state     <= state_next;
            out_valid <= valid_next;
            if (capture) begin
                out_data <= data_in;
                req_seen <= sync_out;
                ack_tgl  <= ~ack_tgl;
                xfer_cnt <= xfer_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tgl_hs_rx.sv
// Directed self-checking bench for tgl_hs_rx.
module tb_tgl_hs_rx;
    import tgl_hs_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_tgl;
    logic [7:0]  data_in;
    logic        ack_tgl;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [15:0] xfer_cnt;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0] rx_q[$];
    bit         rec_en = 1'b0;

    tgl_hs_rx #(
        .DATA_W      (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_tgl   (req_tgl),
        .data_in   (data_in),
        .ack_tgl   (ack_tgl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rec_en && out_valid && out_ready) rx_q.push_back(out_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ack();
        int n = 0;
        while (ack_tgl !== req_tgl && n < 40) begin
            tick();
            n++;
        end
        check("ack_wait", 32'(ack_tgl), 32'(req_tgl));
    endtask

    initial begin
        rstn = 1'b0; req_tgl = 1'b0; data_in = 8'h00; out_ready = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_ack",   32'(ack_tgl),   0);
        check("rst_data",  32'(out_data),  0);
        check("rst_cnt",   32'(xfer_cnt),  0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        tick(2);
        rstn = 1'b1;
        tick();

        // single transfer with latency check
        out_ready = 1'b1;
        data_in = 8'hA5; req_tgl = 1'b1;
        tick(2);
        check("e2_valid", 32'(out_valid), 0);
        check("e2_ack",   32'(ack_tgl),   0);
        tick();
        check("e3_valid", 32'(out_valid), 1);
        check("e3_data",  32'(out_data),  32'h A5);
        check("e3_ack",   32'(ack_tgl),   1);
        check("e3_cnt",   32'(xfer_cnt),  1);
        tick();
        check("e4_valid", 32'(out_valid), 0);
        check("e4_data",  32'(out_data),  32'h A5);

        // backpressure
        out_ready = 1'b0;
        data_in = 8'h11; req_tgl = 1'b0;
        tick(3);
        check("bp_full_valid", 32'(out_valid), 1);
        check("bp_full_data",  32'(out_data),  32'h11);
        check("bp_full_state", 32'(dut.state), 32'(FULL));
        check("bp_full_ack",   32'(ack_tgl),   0);
        data_in = 8'h22; req_tgl = 1'b1;
        tick(3);
        check("bp_stall_state", 32'(dut.state), 32'(STALL));
        check("bp_stall_ack",   32'(ack_tgl),   0);
        check("bp_stall_data",  32'(out_data),  32'h11);
        tick(3);
        check("bp_hold_ack",   32'(ack_tgl),   0);
        check("bp_hold_data",  32'(out_data),  32'h11);
        check("bp_hold_cnt",   32'(xfer_cnt),  2);
        out_ready = 1'b1;
        tick();
        check("bp_rel_data",  32'(out_data),  32'h22);
        check("bp_rel_ack",   32'(ack_tgl),   1);
        check("bp_rel_valid", 32'(out_valid), 1);
        check("bp_rel_cnt",   32'(xfer_cnt),  3);
        check("bp_rel_state", 32'(dut.state), 32'(FULL));
        tick();
        check("bp_drain_valid", 32'(out_valid), 0);
        check("bp_drain_state", 32'(dut.state), 32'(IDLE));

        // asynchronous reset while stalled
        out_ready = 1'b0;
        data_in = 8'h33; req_tgl = 1'b0;
        tick(3);
        data_in = 8'h44; req_tgl = 1'b1;
        tick(3);
        check("mr_stall_state", 32'(dut.state), 32'(STALL));
        #2 rstn = 1'b0;
        #1;
        check("mr_valid", 32'(out_valid), 0);
        check("mr_ack",   32'(ack_tgl),   0);
        check("mr_data",  32'(out_data),  0);
        check("mr_cnt",   32'(xfer_cnt),  0);
        check("mr_state", 32'(dut.state), 32'(IDLE));

        // release with req_tgl still high: one fresh transfer
        tick();
        rstn = 1'b1; out_ready = 1'b1;
        tick(2);
        check("rr_e2_ack",   32'(ack_tgl),   0);
        check("rr_e2_valid", 32'(out_valid), 0);
        tick();
        check("rr_e3_ack",   32'(ack_tgl),   1);
        check("rr_e3_valid", 32'(out_valid), 1);
        check("rr_e3_data",  32'(out_data),  32'h44);
        check("rr_e3_cnt",   32'(xfer_cnt),  1);
        tick(4);
        check("rr_once_cnt",   32'(xfer_cnt),  1);
        check("rr_once_valid", 32'(out_valid), 0);

        // back-to-back stream
        rstn = 1'b0; req_tgl = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        rx_q.delete();
        rec_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_ack();
            data_in = 8'(i);
            req_tgl = ~req_tgl;
        end
        wait_ack();
        tick(2);
        rec_en = 1'b0;
        check("b2b_count", 32'(rx_q.size()), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < rx_q.size()) check("b2b_word", 32'(rx_q[i]), 32'(i));
        end
        check("b2b_cnt", 32'(xfer_cnt), 10);
        check("b2b_ack", 32'(ack_tgl),  0);

        // counter wrap: toggling every cycle captures once per edge
        rstn = 1'b0; req_tgl = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        repeat (65535) begin
            req_tgl = ~req_tgl;
            tick();
        end
        tick(4);
        check("wrap_max", 32'(xfer_cnt), 32'h FFFF);
        req_tgl = ~req_tgl;
        tick(4);
        check("wrap_zero", 32'(xfer_cnt), 32'h 0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
